instr_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the main control decoder.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fetch_out_buf.sv | 44 ++++
 rtl/instr_fetch.sv | 134 +++++++++++++
 tb/tb_instr_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: major opcodes, the canonical NOP
// and the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Major opcode field of an instruction word.
  function automatic logic [6:0] opcodeOf(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready output slot for the fetch stage. A flush empties
// the slot and wins over a load or a consume in the same cycle.
module fetch_out_buf
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic [31:0]     loadInst,
  input  logic [XLEN-1:0] loadPc,
  input  logic            ready,
  output logic            valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] instPc
);

  // Slot occupancy: flush clears, load fills, handshake empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Payload registers: only written when a new word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst   <= NOP_INST;
      instPc <= '0;
    end else if (load && !flush) begin
      inst   <= loadInst;
      instPc <= loadPc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, talks to instruction memory over
// req/ack, and presents fetched words through a one-entry output slot.
//
// Handshakes: a memory transfer happens in a cycle where imem_req && imem_ack;
// while imem_req is high without ack, imem_addr does not change. The output
// slot hands over a word in a cycle where inst_valid && inst_ready; inst and
// inst_pc are stable while inst_valid is high and inst_ready is low.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err,
  output logic [1:0]      dbgState
);

  fetch_state_t    state;
  fetch_state_t    nextState;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] drainAddr;
  logic            misalign;
  logic            slotBlocked;
  logic            xfer;
  logic            pending;
  logic            bufLoad;
  logic            bufFlush;
  logic [XLEN-1:0] alignedTarget;

  // A held word with no consumer means the next fetch would have nowhere to go.
  assign slotBlocked   = inst_valid && !inst_ready;
  // DRAIN keeps presenting the abandoned address until memory answers it.
  assign imem_req      = ((state == FETCH) && !slotBlocked) || (state == DRAIN);
  assign imem_addr     = (state == DRAIN) ? drainAddr : pc;
  assign xfer          = imem_req && imem_ack;
  assign pending       = imem_req && !imem_ack;
  assign alignedTarget = {redirect_pc[XLEN-1:2], 2'b00};
  assign misalign_err  = misalign;
  assign opcode        = opcodeOf(inst);
  assign dbgState      = state;

  // Next-state and slot control; a redirect overrides everything else.
  always_comb begin
    nextState = state;
    bufLoad   = 1'b0;
    bufFlush  = 1'b0;
    case (state)
      IDLE:    nextState = FETCH;
      FETCH: begin
        if (xfer) begin
          bufLoad = 1'b1;
        end else if (slotBlocked) begin
          nextState = FULL;
        end
      end
      FULL:    if (inst_ready) nextState = FETCH;
      DRAIN:   if (imem_ack) nextState = FETCH;
      default: nextState = IDLE;
    endcase
    if (redirect) begin
      bufLoad   = 1'b0;
      bufFlush  = 1'b1;
      nextState = pending ? DRAIN : FETCH;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // PC: redirect target wins, otherwise advance on every accepted word (wraps).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= alignedTarget;
    end else if (bufLoad) begin
      pc <= pc + XLEN'(4);
    end
  end

  // Capture the in-flight address when a redirect abandons it; later
  // redirects during DRAIN leave it alone since that request is still open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drainAddr <= '0;
    end else if (redirect && (state != DRAIN)) begin
      drainAddr <= pc;
    end
  end

  // Sticky flag for any redirect target that was not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end

  fetch_out_buf #(
    .XLEN(XLEN)
  ) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bufFlush),
    .load     (bufLoad),
    .loadInst (imem_rdata),
    .loadPc   (pc),
    .ready    (inst_ready),
    .valid    (inst_valid),
    .inst     (inst),
    .instPc   (inst_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed stimulus, a memory model with a
// programmable ack delay, and a scoreboard of expected delivered PCs.
// Timing per clock: inputs change at posedge+2, memory answers at
// posedge+4, everything is sampled at posedge+6.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic [1:0]  dbgState;

  int          nChecks = 0;
  int          nFails  = 0;
  int          ackDelay = 0;
  int          waitCnt = 0;
  logic        prevPending = 1'b0;
  logic [31:0] prevAddr = 32'h0;
  logic [31:0] exp_q[$];

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .opcode       (opcode),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err),
    .dbgState     (dbgState)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #20000;
    nChecks++;
    nFails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $fatal(1, "watchdog");
  end

  // Memory contents: opcode chosen by address bits [3:2], upper bits scrambled
  function automatic logic [6:0] expOpc(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return OPC_RTYPE;
      2'd1:    return OPC_LOAD;
      2'd2:    return OPC_STORE;
      default: return OPC_BRANCH;
    endcase
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[24:0] ^ 25'h0ABCDEF, expOpc(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic req, input logic [31:0] addr,
                        input logic valid);
    chk({tag, "_req"}, 32'(imem_req), 32'(req));
    chk({tag, "_addr"}, imem_addr, addr);
    chk({tag, "_valid"}, 32'(inst_valid), 32'(valid));
  endtask

  task automatic chkState(input string tag, input fetch_state_t s);
    chk({tag, "_state"}, 32'(dbgState), 32'(s));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory model: ack after ackDelay waiting cycles; also checks address hold
  always begin
    @(posedge clk);
    #4;
    if (imem_req) begin
      if (prevPending) chk("mem_addr_hold", imem_addr, prevAddr);
      if (waitCnt >= ackDelay) begin
        imem_ack   = 1'b1;
        imem_rdata = memWord(imem_addr);
        waitCnt    = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        waitCnt++;
      end
      prevPending = !imem_ack;
      prevAddr    = imem_addr;
    end else begin
      imem_ack    = 1'b0;
      waitCnt     = 0;
      prevPending = 1'b0;
    end
  end

  // Scoreboard monitor: every output handshake must match the queue head
  always begin
    @(posedge clk);
    #6;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL sb_unexpected: got pc %h with nothing expected", inst_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst, memWord(e));
        chk("sb_opcode", 32'(opcode), 32'(expOpc(e)));
      end
    end
  end

  // Directed stimulus
  initial begin
    rst_n       = 1'b0;
    inst_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    #4;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, NOP_INST);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'h13);
    step();
    rst_n = 1'b1;

    // 1: streaming at one instruction per clock
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    step(); #4; chkOut("t1_c1", 1'b1, 32'h0, 1'b0); chkState("t1_c1", FETCH);
    step(); #4; chkOut("t1_c2", 1'b1, 32'h4, 1'b1); chk("t1_c2_pc", inst_pc, 32'h0);

    // 2: memory answers the 0x8 request after three waiting cycles
    step(); ackDelay = 3; #4;
    chkOut("t2_c0", 1'b1, 32'h8, 1'b1); chk("t2_c0_pc", inst_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(); #4; chkOut("t2_wait", 1'b1, 32'h8, 1'b0);
    end

    // 3: downstream stalls for five cycles
    step(); ackDelay = 0; inst_ready = 1'b0; #4;
    chkOut("t3_c0", 1'b0, 32'hC, 1'b1);
    chk("t3_c0_pc", inst_pc, 32'h8);
    chk("t3_c0_inst", inst, memWord(32'h8));
    for (int i = 0; i < 4; i++) begin
      step(); #4;
      chkOut("t3_stall", 1'b0, 32'hC, 1'b1);
      chk("t3_stall_pc", inst_pc, 32'h8);
      chk("t3_stall_inst", inst, memWord(32'h8));
      chkState("t3_stall", FULL);
    end
    step(); inst_ready = 1'b1; #4; chkOut("t3_rdy", 1'b0, 32'hC, 1'b1); chkState("t3_rdy", FULL);
    step(); #4; chkOut("t3_resume", 1'b1, 32'hC, 1'b0); chkState("t3_resume", FETCH);

    // 4: redirect while the 0x10 request is outstanding
    step(); ackDelay = 3; #4; chkOut("t4_c0", 1'b1, 32'h10, 1'b1); chk("t4_c0_pc", inst_pc, 32'hC);
    step(); redirect = 1'b1; redirect_pc = 32'h100; #4; chkOut("t4_rd", 1'b1, 32'h10, 1'b0);
    step(); redirect = 1'b0; #4; chkOut("t4_drain1", 1'b1, 32'h10, 1'b0); chkState("t4_drain1", DRAIN);
    step(); #4; chkOut("t4_drain2", 1'b1, 32'h10, 1'b0); chkState("t4_drain2", DRAIN);
    exp_q.push_back(32'h100);
    step(); ackDelay = 0; #4; chkOut("t4_new", 1'b1, 32'h100, 1'b0); chkState("t4_new", FETCH);

    // 5: misaligned redirect, then PC wrap at the top of the address space
    step(); redirect = 1'b1; redirect_pc = 32'h202; #4;
    chkOut("t5_c0", 1'b1, 32'h104, 1'b1); chk("t5_c0_pc", inst_pc, 32'h100);
    exp_q.push_back(32'h200);
    step(); redirect = 1'b0; #4;
    chkOut("t5_align", 1'b1, 32'h200, 1'b0); chk("t5_misalign", 32'(misalign_err), 32'd1);
    step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #4;
    chkOut("t5_c2", 1'b1, 32'h204, 1'b1); chk("t5_c2_pc", inst_pc, 32'h200);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    step(); redirect = 1'b0; #4;
    chkOut("t5_top", 1'b1, 32'hFFFF_FFFC, 1'b0); chk("t5_sticky", 32'(misalign_err), 32'd1);
    step(); #4; chkOut("t5_wrap", 1'b1, 32'h0, 1'b1); chk("t5_wrap_pc", inst_pc, 32'hFFFF_FFFC);
    step(); ackDelay = 4; #4; chkOut("t5_after", 1'b1, 32'h4, 1'b1); chk("t5_after_pc", inst_pc, 32'h0);

    // Back-to-back redirects during DRAIN: the last target is fetched
    step(); redirect = 1'b1; redirect_pc = 32'h40; #4; chkOut("t6_rd1", 1'b1, 32'h4, 1'b0);
    step(); redirect_pc = 32'h80; #4; chkOut("t6_rd2", 1'b1, 32'h4, 1'b0); chkState("t6_rd2", DRAIN);
    step(); redirect = 1'b0; #4; chkOut("t6_d1", 1'b1, 32'h4, 1'b0); chkState("t6_d1", DRAIN);
    step(); #4; chkOut("t6_d2", 1'b1, 32'h4, 1'b0); chkState("t6_d2", DRAIN);
    step(); ackDelay = 3; #4; chkOut("t6_last", 1'b1, 32'h80, 1'b0); chkState("t6_last", FETCH);

    // 6: reset asserted in the middle of a DRAIN
    step(); redirect = 1'b1; redirect_pc = 32'h300; #4; chkOut("t7_pend", 1'b1, 32'h80, 1'b0);
    step(); redirect = 1'b0; #4;
    chkOut("t7_drain", 1'b1, 32'h80, 1'b0); chkState("t7_drain", DRAIN);
    chk("t7_misalign", 32'(misalign_err), 32'd1);
    step(); rst_n = 1'b0; #1;
    chkOut("t7_arst", 1'b0, 32'h0, 1'b0);
    chkState("t7_arst", IDLE);
    chk("t7_arst_inst", inst, NOP_INST);
    chk("t7_arst_pc", inst_pc, 32'h0);
    chk("t7_arst_misalign", 32'(misalign_err), 32'd0);
    chk("t7_arst_opcode", 32'(opcode), 32'h13);
    ackDelay = 0;
    exp_q.push_back(32'h0);
    step(); rst_n = 1'b1;
    step(); #4; chkOut("t7_restart", 1'b1, 32'h0, 1'b0);
    step(); #4; chkOut("t7_first", 1'b1, 32'h4, 1'b1); chk("t7_first_pc", inst_pc, 32'h0);
    step(); inst_ready = 1'b0; #4;
    chkOut("t7_hold", 1'b0, 32'h8, 1'b1); chk("t7_hold_pc", inst_pc, 32'h4);
    step(); #4; chkState("t7_full", FULL);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
